// File: rtl/hnull_arb2.sv
// hnull_arb2 - two-input, one-output round-robin channel arbiter.
//
// Merges two upstream 4-phase req/ack channels (rcv0, rcv1) onto one
// downstream channel (snd0). The winner's src/dst/dat/red are latched when it
// is granted and held until the next grant. Input requests are debounced:
// a req counts as checked only after RCV_REQ_CKS consecutive high cycles.
//
// Ports:
//   gch_clk, gch_reset      clock, synchronous active-high reset
//   gch_ready               block initialised and both debouncers ready
//   rcvN_req/rcvN_ack_out   input N handshake (N = 0, 1)
//   rcvN_src/dst/dat/red    input N packet fields
//   snd0_req_out/snd0_ack   output handshake
//   snd0_src/dst/dat/red    latched packet fields of the granted input
//   err0_error/src/dst/dat  protocol error report (src is MY_LOCAL_ADDR)
//
// Optional feature macro: HARB_PROTO_CHK_EN
//   Defined   - sticky protocol checker drives err0_error/dst/dat.
//   Undefined - err0_error/dst/dat tie to 0 and no checker is built.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

module hnull_arb2 #(
  parameter int unsigned MY_LOCAL_ADDR = 0,
  parameter int unsigned ASZ           = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ           = `NS_DATA_SIZE,
  parameter int unsigned RSZ           = `NS_REDUN_SIZE,
  parameter int unsigned RCV_REQ_CKS   = `NS_REQ_CKS,
  parameter int unsigned FIRST_PRI     = 0
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,

  input  logic           rcv0_req,
  output logic           rcv0_ack_out,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,

  input  logic           rcv1_req,
  output logic           rcv1_ack_out,
  input  logic [ASZ-1:0] rcv1_src,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,

  output logic           snd0_req_out,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,

  output logic           err0_error,
  output logic [ASZ-1:0] err0_src,
  output logic [ASZ-1:0] err0_dst,
  output logic [DSZ-1:0] err0_dat
);

  typedef enum logic [1:0] {StIdle, StSend, StRelease} state_e;

  // Counter wide enough to hold RCV_REQ_CKS; saturates there.
  localparam int unsigned CW = (RCV_REQ_CKS < 1) ? 1 : $clog2(RCV_REQ_CKS + 1);
  localparam logic [CW-1:0] CksVal = CW'(RCV_REQ_CKS);
  localparam logic PriInit = FIRST_PRI[0];

  // ---------------------------------------------------------------------------
  // Request debouncers
  // ---------------------------------------------------------------------------
  logic [1:0]         w_req;
  logic [1:0]         w_ckd;
  logic [1:0][CW-1:0] r_cnt;
  logic [1:0]         r_db_rdy;

  assign w_req = {rcv1_req, rcv0_req};

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      r_cnt    <= '0;
      r_db_rdy <= 2'b00;
    end else begin
      r_db_rdy <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        if (!w_req[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CksVal) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_ckd[i] = (r_cnt[i] == CksVal);
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter state
  // ---------------------------------------------------------------------------
  logic           r_rdy;
  state_e         r_state, w_state_nxt;
  logic           r_grant, w_grant_nxt;
  logic           r_pri, w_pri_nxt;
  logic           r_snd_req, w_snd_req_nxt;
  logic [1:0]     r_ack, w_ack_nxt;
  logic [ASZ-1:0] r_src, w_src_nxt;
  logic [ASZ-1:0] r_dst, w_dst_nxt;
  logic [DSZ-1:0] r_dat, w_dat_nxt;
  logic [RSZ-1:0] r_red, w_red_nxt;

  // State is cleared during reset and again in the first cycle after it.
  logic w_clear;
  assign w_clear = gch_reset || !r_rdy;

  // Winner when both are checked is the priority holder; otherwise whichever
  // is checked (rcv1 only if rcv0 is not).
  logic           w_win;
  logic [ASZ-1:0] w_in_src, w_in_dst;
  logic [DSZ-1:0] w_in_dat;
  logic [RSZ-1:0] w_in_red;

  always_comb begin
    w_win    = (w_ckd == 2'b11) ? r_pri : w_ckd[1];
    w_in_src = w_win ? rcv1_src : rcv0_src;
    w_in_dst = w_win ? rcv1_dst : rcv0_dst;
    w_in_dat = w_win ? rcv1_dat : rcv0_dat;
    w_in_red = w_win ? rcv1_red : rcv0_red;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_pri_nxt     = r_pri;
    w_snd_req_nxt = r_snd_req;
    w_ack_nxt     = r_ack;
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    w_dat_nxt     = r_dat;
    w_red_nxt     = r_red;

    unique case (r_state)
      StIdle: begin
        if (|w_ckd) begin
          w_src_nxt     = w_in_src;
          w_dst_nxt     = w_in_dst;
          w_dat_nxt     = w_in_dat;
          w_red_nxt     = w_in_red;
          w_grant_nxt   = w_win;
          w_snd_req_nxt = 1'b1;
          w_state_nxt   = StSend;
        end
      end
      StSend: begin
        if (snd0_ack) begin
          w_snd_req_nxt      = 1'b0;
          w_ack_nxt[r_grant] = 1'b1;
          w_state_nxt        = StRelease;
        end
      end
      StRelease: begin
        // Wait for both sides of the 4-phase handshake to return to zero.
        if (!snd0_ack && !w_ckd[r_grant]) begin
          w_ack_nxt[r_grant] = 1'b0;
          w_pri_nxt          = ~r_grant;
          w_state_nxt        = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge gch_clk) begin
    r_rdy <= !gch_reset;
    if (w_clear) begin
      r_state   <= StIdle;
      r_grant   <= 1'b0;
      r_pri     <= PriInit;
      r_snd_req <= 1'b0;
      r_ack     <= 2'b00;
      r_src     <= '0;
      r_dst     <= '0;
      r_dat     <= '0;
      r_red     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_pri     <= w_pri_nxt;
      r_snd_req <= w_snd_req_nxt;
      r_ack     <= w_ack_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_dat     <= w_dat_nxt;
      r_red     <= w_red_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------------
`ifdef HARB_PROTO_CHK_EN
  logic           r_err, w_err_nxt;
  logic [ASZ-1:0] r_err_dst, w_err_dst_nxt;
  logic [DSZ-1:0] r_err_dat, w_err_dat_nxt;

  // Sticky: the first violation's code and dst are kept until reset.
  always_comb begin
    w_err_nxt     = r_err;
    w_err_dst_nxt = r_err_dst;
    w_err_dat_nxt = r_err_dat;
    if (!r_err) begin
      if (r_state == StIdle && snd0_ack) begin
        w_err_nxt     = 1'b1;
        w_err_dst_nxt = '0;
        w_err_dat_nxt = DSZ'(1);
      end else if (r_state == StSend && !w_req[r_grant]) begin
        w_err_nxt     = 1'b1;
        w_err_dst_nxt = r_dst;
        w_err_dat_nxt = DSZ'(2);
      end
    end
  end

  always_ff @(posedge gch_clk) begin
    if (w_clear) begin
      r_err     <= 1'b0;
      r_err_dst <= '0;
      r_err_dat <= '0;
    end else begin
      r_err     <= w_err_nxt;
      r_err_dst <= w_err_dst_nxt;
      r_err_dat <= w_err_dat_nxt;
    end
  end

  assign err0_error = r_err;
  assign err0_dst   = r_err_dst;
  assign err0_dat   = r_err_dat;
`else
  assign err0_error = 1'b0;
  assign err0_dst   = '0;
  assign err0_dat   = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gch_ready    = r_rdy && r_db_rdy[0] && r_db_rdy[1];
  assign rcv0_ack_out = r_ack[0];
  assign rcv1_ack_out = r_ack[1];
  assign snd0_req_out = r_snd_req;
  assign snd0_src     = r_src;
  assign snd0_dst     = r_dst;
  assign snd0_dat     = r_dat;
  assign snd0_red     = r_red;
  assign err0_src     = ASZ'(MY_LOCAL_ADDR);

endmodule

// File: tb/tb_hnull_arb2.sv
// tb_hnull_arb2 - self-checking bench for hnull_arb2.
// A transaction-level reference model tracks debounce history, the current
// transfer and priority; a negedge compare process checks every DUT output
// against it each cycle. Directed scenarios add literal expectations.

module tb_hnull_arb2;
  localparam int ASZ   = 6;
  localparam int DSZ   = 4;
  localparam int RSZ   = 4;
  localparam int CKS   = 2;
  localparam int FPRI  = 0;
  localparam int LADDR = 21;
  localparam logic [ASZ-1:0] LSRC = ASZ'(LADDR);
`ifdef HARB_PROTO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready;
  logic [1:0]     rq = 2'b00;
  logic [ASZ-1:0] src[2], dst[2];
  logic [DSZ-1:0] dat[2];
  logic [RSZ-1:0] red[2];
  logic [1:0]     ack_o;
  logic           s_req;
  logic           s_ack = 1'b0;
  logic [ASZ-1:0] s_src, s_dst;
  logic [DSZ-1:0] s_dat;
  logic [RSZ-1:0] s_red;
  logic           e_err;
  logic [ASZ-1:0] e_src, e_dst;
  logic [DSZ-1:0] e_dat;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  hnull_arb2 #(
    .MY_LOCAL_ADDR(LADDR), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
    .RCV_REQ_CKS(CKS), .FIRST_PRI(FPRI)
  ) dut (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(ready),
    .rcv0_req(rq[0]), .rcv0_ack_out(ack_o[0]), .rcv0_src(src[0]), .rcv0_dst(dst[0]),
    .rcv0_dat(dat[0]), .rcv0_red(red[0]),
    .rcv1_req(rq[1]), .rcv1_ack_out(ack_o[1]), .rcv1_src(src[1]), .rcv1_dst(dst[1]),
    .rcv1_dat(dat[1]), .rcv1_red(red[1]),
    .snd0_req_out(s_req), .snd0_ack(s_ack), .snd0_src(s_src), .snd0_dst(s_dst),
    .snd0_dat(s_dat), .snd0_red(s_red),
    .err0_error(e_err), .err0_src(e_src), .err0_dst(e_dst), .err0_dat(e_dat)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: updated on each rising edge from the bench-driven inputs.
  // m_hi counts consecutive high samples of each req; m_busy/m_draining
  // describe the transfer in flight.
  // ---------------------------------------------------------------------------
  int             m_hi[2];
  bit             m_rdy = 1'b0;
  bit             m_busy = 1'b0;
  bit             m_draining = 1'b0;
  int             m_pri = FPRI;
  int             m_grant = 0;
  bit             m_req = 1'b0;
  bit [1:0]       m_ack = 2'b00;
  logic [ASZ-1:0] m_src = '0, m_dst = '0;
  logic [DSZ-1:0] m_dat = '0;
  logic [RSZ-1:0] m_red = '0;
  bit             m_err = 1'b0;
  logic [ASZ-1:0] m_edst = '0;
  logic [DSZ-1:0] m_edat = '0;

  always @(posedge clk) begin
    bit checked[2];
    int g;
    for (int i = 0; i < 2; i++) checked[i] = (m_hi[i] >= CKS);
    for (int i = 0; i < 2; i++) m_hi[i] = (rst || !rq[i]) ? 0 : m_hi[i] + 1;
    if (rst || !m_rdy) begin
      m_rdy = !rst;
      m_busy = 0; m_draining = 0; m_pri = FPRI; m_grant = 0;
      m_req = 0; m_ack = 2'b00;
      m_src = '0; m_dst = '0; m_dat = '0; m_red = '0;
      m_err = 0; m_edst = '0; m_edat = '0;
    end else if (!m_busy) begin
      if (CHK && !m_err && s_ack) begin
        m_err = 1; m_edat = 4'd1; m_edst = '0;
      end
      if (checked[0] || checked[1]) begin
        if (checked[0] && checked[1]) g = m_pri;
        else g = checked[0] ? 0 : 1;
        m_grant = g;
        m_src = src[g]; m_dst = dst[g]; m_dat = dat[g]; m_red = red[g];
        m_req = 1; m_busy = 1;
      end
    end else if (!m_draining) begin
      if (CHK && !m_err && !rq[m_grant]) begin
        m_err = 1; m_edat = 4'd2; m_edst = m_dst;
      end
      if (s_ack) begin
        m_req = 0; m_ack[m_grant] = 1; m_draining = 1;
      end
    end else if (!s_ack && !checked[m_grant]) begin
      m_ack[m_grant] = 0; m_pri = 1 - m_grant; m_busy = 0; m_draining = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("handshake", 64'({ready, s_req, ack_o}), 64'({m_rdy, m_req, m_ack}));
      chk("fields", 64'({s_src, s_dst, s_dat, s_red}), 64'({m_src, m_dst, m_dat, m_red}));
      chk("error", 64'({e_err, e_dst, e_dat, e_src}), 64'({m_err, m_edst, m_edat, LSRC}));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus agents (driven only from the main initial block)
  // ---------------------------------------------------------------------------
  int pst[2] = '{0, 0};  // 0 idle, 1 requesting, 2 wait ack low, 3 glitch
  int cst = 0;           // 0 wait req, 1 ack delay, 2 wait req low, 3 release delay
  int cdly = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_pkt(input int i, input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                         input logic [DSZ-1:0] a, input logic [RSZ-1:0] r);
    src[i] = s; dst[i] = d; dat[i] = a; red[i] = r;
  endtask

  task automatic rand_pkt(input int i);
    set_pkt(i, ASZ'($urandom), ASZ'($urandom), DSZ'($urandom), RSZ'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; rq = 2'b00; s_ack = 1'b0;
    pst[0] = 0; pst[1] = 0; cst = 0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic step(input int rpct, input int gpct, input int amax);
    for (int i = 0; i < 2; i++) begin
      case (pst[i])
        0: begin
          if ($urandom_range(0, 99) < rpct) begin
            rand_pkt(i); rq[i] = 1'b1; pst[i] = 1;
          end else if ($urandom_range(0, 99) < gpct) begin
            rand_pkt(i); rq[i] = 1'b1; pst[i] = 3;
          end
        end
        1: if (ack_o[i]) begin rq[i] = 1'b0; pst[i] = 2; end
        2: if (!ack_o[i]) pst[i] = 0;
        default: begin rq[i] = 1'b0; pst[i] = 0; end
      endcase
    end
    if (cst == 0 && s_req) begin cdly = $urandom_range(0, amax); cst = 1; end
    if (cst == 1) begin
      if (cdly == 0) begin s_ack = 1'b1; cst = 2; end
      else cdly--;
    end else if (cst == 2 && !s_req) begin
      cdly = $urandom_range(0, amax); cst = 3;
    end
    if (cst == 3) begin
      if (cdly == 0) begin s_ack = 1'b0; cst = 0; end
      else cdly--;
    end
    tick();
  endtask

  task automatic drain();
    bit quiet;
    quiet = 0;
    for (int c = 0; c < 300; c++) begin
      quiet = (pst[0] == 0 && pst[1] == 0 && cst == 0 && !s_req && ack_o == 2'b00);
      if (quiet) break;
      step(0, 0, 1);
    end
    chk("drain_idle", 64'(quiet), 64'(1));
  endtask

  task automatic wait_sig(input string nm, input int which, input bit val, input int maxc);
    logic v;
    for (int c = 0; c < maxc; c++) begin
      v = (which == 0) ? s_req : ack_o[which-1];
      if (v == val) break;
      tick();
    end
    v = (which == 0) ? s_req : ack_o[which-1];
    chk(nm, 64'(v), 64'(val));
  endtask

  int gord[4];
  int exp_ord[4] = '{0, 1, 0, 1};

  initial begin
    int gn;
    int rp, gp, am;
    logic [1:0] pv;
    for (int i = 0; i < 2; i++) set_pkt(i, '0, '0, '0, '0);

    // 1: reset for 3 cycles, then release
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    chk("t1_ready_in_reset", 64'(ready), 64'(0));
    rst = 1'b0;
    tick(); tick();
    chk("t1_ready", 64'(ready), 64'(1));
    chk("t1_hs_idle", 64'({s_req, ack_o}), 64'(0));

    // 2: single packet on rcv0, consumer acks 2 cycles after req
    set_pkt(0, 6'd1, 6'd5, 4'hA, 4'h3);
    rq[0] = 1'b1;
    wait_sig("t2_req", 0, 1'b1, 20);
    chk("t2_dst", 64'(s_dst), 64'(5));
    chk("t2_dat", 64'(s_dat), 64'(4'hA));
    tick(); tick();
    s_ack = 1'b1;
    tick();
    chk("t2_ack_rise", 64'(ack_o), 64'(2'b01));
    chk("t2_req_low", 64'(s_req), 64'(0));
    rq[0] = 1'b0; s_ack = 1'b0;
    tick();
    chk("t2_ack_hold", 64'(ack_o[0]), 64'(1));
    wait_sig("t2_ack_fall", 1, 1'b0, 20);

    // 3: both request together after fresh reset, four packets round robin
    do_reset(2);
    tick(); tick();
    rand_pkt(0); rand_pkt(1);
    rq = 2'b11; pst[0] = 1; pst[1] = 1;
    gn = 0; pv = ack_o;
    for (int c = 0; c < 400 && gn < 4; c++) begin
      step(100, 0, 2);
      for (int i = 0; i < 2; i++) begin
        if (ack_o[i] && !pv[i]) begin
          if (gn < 4) gord[gn] = i;
          gn++;
        end
      end
      pv = ack_o;
    end
    chk("t3_grant_count", 64'(gn >= 4), 64'(1));
    for (int k = 0; k < 4; k++) chk($sformatf("t3_grant%0d", k), 64'(gord[k]), 64'(exp_ord[k]));
    drain();

    // 4: rcv0 data changes during SEND, latched value holds
    set_pkt(0, 6'd2, 6'd7, 4'h3, 4'h1);
    rq[0] = 1'b1;
    wait_sig("t4_req", 0, 1'b1, 20);
    dat[0] = 4'hC;
    tick();
    chk("t4_hold_send", 64'(s_dat), 64'(4'h3));
    s_ack = 1'b1;
    wait_sig("t4_ack", 1, 1'b1, 10);
    chk("t4_hold_release", 64'(s_dat), 64'(4'h3));
    rq[0] = 1'b0; s_ack = 1'b0;
    wait_sig("t4_ack_fall", 1, 1'b0, 20);
    chk("t4_hold_after", 64'(s_dat), 64'(4'h3));

    // 5: reset pulsed during SEND; priority returns to input 0
    set_pkt(1, 6'd4, 6'h22, 4'h5, 4'h2);
    rq[1] = 1'b1;
    wait_sig("t5_req", 0, 1'b1, 20);
    do_reset(1);
    chk("t5_abort", 64'({s_req, ack_o}), 64'(0));
    set_pkt(0, 6'd8, 6'h11, 4'h6, 4'h4);
    set_pkt(1, 6'd9, 6'h22, 4'h7, 4'h5);
    rq = 2'b11; pst[0] = 1; pst[1] = 1;
    wait_sig("t5_req2", 0, 1'b1, 20);
    chk("t5_first_pri", 64'(s_dst), 64'(6'h11));
    drain();

    // 6: protocol violations
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    tick();
    chk("t6_idle_ack", 64'({e_err, e_dat, e_dst}), CHK ? 64'({1'b1, 4'd1, 6'd0}) : 64'(0));
    repeat (5) tick();
    chk("t6_sticky", 64'(e_err), 64'(CHK));
    do_reset(2);
    chk("t6_clear", 64'(e_err), 64'(0));
    tick(); tick(); tick();
    set_pkt(0, 6'd3, 6'h2A, 4'h5, 4'h1);
    rq[0] = 1'b1;
    wait_sig("t6_req", 0, 1'b1, 20);
    rq[0] = 1'b0;
    tick();
    chk("t6_req_drop", 64'({e_err, e_dat, e_dst}), CHK ? 64'({1'b1, 4'd2, 6'h2A}) : 64'(0));
    s_ack = 1'b1;
    wait_sig("t6_ack", 1, 1'b1, 10);
    s_ack = 1'b0;
    wait_sig("t6_ack_fall", 1, 1'b0, 20);
    do_reset(1);

    // Randomised traffic with glitches, varied ack latency and sparse resets
    rp = 50; gp = 10; am = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        rp = $urandom_range(5, 100);
        gp = $urandom_range(0, 30);
        am = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 599) == 0) do_reset($urandom_range(1, 2));
      else step(rp, gp, am);
    end
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hnull_arb2.md
Name: hnull_arb2

Overview:
Two-input, one-output channel arbiter for the NS network fabric.
- Merges two upstream 4-phase req/ack channels (rcv0, rcv1) onto one downstream channel (snd0) with round-robin fairness.
- Forwards each packet's dst/dat/red fields unchanged.
- Sits between two producers (or two hnull_* sources) and a single consumer such as a sink or router port.

Parameters:
- MY_LOCAL_ADDR, 0, address this node reports on its error channel.
- ASZ, `NS_ADDRESS_SIZE, width of the src/dst fields.
- DSZ, `NS_DATA_SIZE, width of the data field.
- RSZ, `NS_REDUN_SIZE, width of the redundancy field.
- RCV_REQ_CKS, `NS_REQ_CKS, consecutive high cycles before an input req counts as checked (debounce depth, ≥1).
- FIRST_PRI, 0, input that holds priority after reset (0 or 1).

Ports:
- gch_clk  in  1  clock; all logic on the rising edge.
- gch_reset  in  1  synchronous, active-high reset.
- gch_ready  out  1  block initialised and both input debouncers ready.
- rcvN_req  in  1  input N request (N=0,1).
- rcvN_ack_out  out  1  input N acknowledge.
- rcvN_src  in  ASZ  input N source address.
- rcvN_dst  in  ASZ  input N destination address.
- rcvN_dat  in  DSZ  input N data.
- rcvN_red  in  RSZ  input N redundancy.
- snd0_req_out  out  1  output request.
- snd0_ack  in  1  output acknowledge.
- snd0_src  out  ASZ  latched source address.
- snd0_dst  out  ASZ  latched destination address.
- snd0_dat  out  DSZ  latched data.
- snd0_red  out  RSZ  latched redundancy.
- err0_error  out  1  protocol error flag.
- err0_src  out  ASZ  MY_LOCAL_ADDR.
- err0_dst  out  ASZ  dst of the offending packet.
- err0_dat  out  DSZ  error code.

Behaviour:
Reset and init
- While gch_reset is high: rg_rdy=0, all ack/req outputs 0, snd0 field regs 0, priority=FIRST_PRI, state=IDLE, err outputs 0.
- First cycle after reset deasserts: rg_rdy<=1; all state is re-cleared again in that cycle.
- gch_ready = rg_rdy && rcv0_rdy && rcv1_rdy.
- Reset asserted mid-transfer aborts immediately; no partial handshake is completed.

Debounce
- rcvN_ckd_req is 1 only after rcvN_req has been high for RCV_REQ_CKS consecutive cycles.
- Any low cycle clears the count.

State machine (only while rg_rdy):
- IDLE:
  - Winner = the input with ckd_req; if both are checked, the input equal to priority wins.
  - Latch the winner's src/dst/dat/red into the snd0 regs; grant<=winner; snd0_req_out<=1; go SEND.
  - Minimum latency from checked req to snd0_req_out: 1 cycle.
- SEND:
  - Hold the fields stable.
  - On snd0_ack=1: snd0_req_out<=0, rcv[grant]_ack_out<=1, go RELEASE.
- RELEASE:
  - When snd0_ack=0 AND rcv[grant]_ckd_req=0: rcv[grant]_ack_out<=0, priority<=~grant, go IDLE.
  - Otherwise hold.
- The non-granted input is never acked; its req is simply held off.
- Round robin: after serving input g, the other input has priority. The same input is served twice in a row only if the other has no checked req in IDLE.
- Fields latched in IDLE do not change until the next IDLE grant, even if the rcv inputs change.

Optional Feature:
HARB_PROTO_CHK_EN
- Defined: err0_error latches to 1 (sticky until reset) on either violation:
  - snd0_ack=1 while in IDLE: err0_dat=1, err0_dst=0.
  - rcv[grant]_req drops while in SEND: err0_dat=2, err0_dst=latched dst.
  - On a violation the FSM still proceeds normally.
  - err0_src=MY_LOCAL_ADDR.
- Not defined: err0_error, err0_dst and err0_dat are constant 0; err0_src=MY_LOCAL_ADDR; no checker logic is synthesised.

Test Plan:
Parameters for all tests: ASZ=6, DSZ=4, RSZ=4, RCV_REQ_CKS=2.
1. Reset held for 3 cycles, then released.
   -> gch_ready=1 by the 2nd cycle after release; all req/ack outputs 0.
2. rcv0 only (dst=5, dat=0xA); consumer acks 2 cycles after snd0_req_out.
   -> snd0_dst=5, snd0_dat=0xA; rcv0_ack_out rises the cycle after snd0_ack; it falls after both rcv0_req and snd0_ack are low.
3. rcv0 and rcv1 raise req in the same cycle, FIRST_PRI=0, both re-request immediately, 4 packets.
   -> grants in order 0,1,0,1.
4. During SEND, change rcv0_dat from 0x3 to 0xC.
   -> snd0_dat stays 0x3 until RELEASE completes.
5. Reset pulsed while in SEND.
   -> next cycle snd0_req_out=0 and rcv0_ack_out=0; priority returns to FIRST_PRI.
6. With HARB_PROTO_CHK_EN defined, drive snd0_ack=1 while IDLE.
   -> err0_error=1, err0_dat=1, and it stays 1 until reset; without the macro, err0_error stays 0.
